actuador_puertas: RTL

Door actuator stage of the elevator car. Sits directly downstream of the door-control logic. It consumes that logic's `salida_puertas` command and runs the door through its physical travel with a position counter. It returns the door status `puertas` and the open-hold `timeout` that the door control consumes on the next evaluation. It also drives the door motor.

---
 rtl/ascensor_pkg.sv | 23 ++
 rtl/actuador_puertas_contador_sat.sv | 31 +++
 rtl/actuador_puertas.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ascensor_pkg.sv
// Shared elevator definitions: door status encoding, door-control
// command codes and motor drive codes.
package ascensor_pkg;

    // Door status; the encoding is what appears on the puertas output.
    typedef enum logic [1:0] {
        PUERTA_CERRADA  = 2'b00,
        PUERTA_ABIERTA  = 2'b01,
        PUERTA_CERRANDO = 2'b10,
        PUERTA_ABRIENDO = 2'b11
    } puerta_t;

    // Door-control commands (11 is treated as CMD_NADA).
    localparam logic [1:0] CMD_NADA   = 2'b00;
    localparam logic [1:0] CMD_ABRIR  = 2'b01;
    localparam logic [1:0] CMD_CERRAR = 2'b10;

    // Motor drive codes.
    localparam logic [1:0] MOTOR_PARO   = 2'b00;
    localparam logic [1:0] MOTOR_ABRIR  = 2'b01;
    localparam logic [1:0] MOTOR_CERRAR = 2'b10;

endpackage

// File: rtl/actuador_puertas_contador_sat.sv
// Saturating up-counter with synchronous clear; used for the door
// open-hold time.
module contador_sat #(
    parameter int MAX = 100,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] valor,
    output logic         lleno
);

    localparam logic [W-1:0] VALOR_MAX = W'(MAX);

    // Count up while enabled, stop at MAX; clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            valor <= '0;
        end else if (clr) begin
            valor <= '0;
        end else if (en && (valor != VALOR_MAX)) begin
            valor <= valor + 1'b1;
        end
    end

    assign lleno = (valor == VALOR_MAX);

endmodule

// File: rtl/actuador_puertas.sv
// Door actuator: runs the door through its travel with a position
// counter, reports door status and the open-hold timeout, drives the motor.
// Optional feature: define ACTUADOR_REVERSA_SENSOR_EN so the obstruction
// sensor reverses a closing door and restarts the open-hold time.
module actuador_puertas
    import ascensor_pkg::*;
#(
    parameter int T_RECORRIDO = 8,
    parameter int T_ABIERTA   = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] salida_puertas,
    input  logic       sensor,
    input  logic       moviendo,
    output logic [1:0] puertas,
    output logic       timeout,
    output logic [1:0] motor
);

    localparam int POS_W  = $clog2(T_RECORRIDO + 1);
    localparam int HOLD_W = $clog2(T_ABIERTA + 1);

    localparam logic [POS_W-1:0] POS_ABIERTA = POS_W'(T_RECORRIDO);
    localparam logic [POS_W-1:0] POS_ULTIMO  = POS_W'(T_RECORRIDO - 1);
    localparam logic [POS_W-1:0] POS_UNO     = POS_W'(1);

    puerta_t            estado, estado_sig;
    logic [POS_W-1:0]   pos, pos_sig;
    logic [HOLD_W-1:0]  hold;
    logic               hold_lleno;
    logic               cmd_abrir, cmd_cerrar;
    logic               reversa, sensor_hold, hold_clr;

    assign cmd_abrir  = (salida_puertas == CMD_ABRIR);
    assign cmd_cerrar = (salida_puertas == CMD_CERRAR);

`ifdef ACTUADOR_REVERSA_SENSOR_EN
    assign reversa     = cmd_abrir | sensor;
    assign sensor_hold = sensor;
`else
    // The obstruction sensor is deliberately ignored in this build.
    assign reversa     = cmd_abrir;
    assign sensor_hold = sensor & 1'b0;
`endif

    // Hold time only runs while fully open; any other state keeps it at zero
    // so entering ABIERTA always starts from a fresh count.
    assign hold_clr = (estado != PUERTA_ABIERTA) | cmd_abrir | sensor_hold;

    contador_sat #(
        .MAX (T_ABIERTA),
        .W   (HOLD_W)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (hold_clr),
        .en      (estado == PUERTA_ABIERTA),
        .valor   (hold),
        .lleno   (hold_lleno)
    );

    // State and door position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= PUERTA_CERRADA;
            pos    <= '0;
        end else begin
            estado <= estado_sig;
            pos    <= pos_sig;
        end
    end

    // Next state and next position from the current state and command.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        estado_sig = estado;
        pos_sig    = pos;
        case (estado)
            PUERTA_CERRADA: begin
                pos_sig = '0;
                if (cmd_abrir && !moviendo) estado_sig = PUERTA_ABRIENDO;
            end
            PUERTA_ABRIENDO: begin
                // ">=" also finishes a reversal taken at the very top of travel,
                // keeping pos within 0..T_RECORRIDO.
                if (pos >= POS_ULTIMO) begin
                    estado_sig = PUERTA_ABIERTA;
                    pos_sig    = POS_ABIERTA;
                end else begin
                    pos_sig = pos + 1'b1;
                end
            end
            PUERTA_ABIERTA: begin
                pos_sig = POS_ABIERTA;
                if (cmd_cerrar) estado_sig = PUERTA_CERRANDO;
            end
            PUERTA_CERRANDO: begin
                // Reversal wins over completion; position is held on that cycle.
                if (reversa) begin
                    estado_sig = PUERTA_ABRIENDO;
                end else if (pos <= POS_UNO) begin
                    estado_sig = PUERTA_CERRADA;
                    pos_sig    = '0;
                end else begin
                    pos_sig = pos - 1'b1;
                end
            end
            default: begin
                estado_sig = PUERTA_CERRADA;
                pos_sig    = '0;
            end
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        puertas = estado;
        timeout = (estado == PUERTA_ABIERTA) && hold_lleno;
        case (estado)
            PUERTA_ABRIENDO: motor = MOTOR_ABRIR;
            PUERTA_CERRANDO: motor = MOTOR_CERRAR;
            default:         motor = MOTOR_PARO;
        endcase
    end

endmodule
